alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Parametrised ID/EX operand stage for the MIPS pipeline that generalises the ALU B-source select. It resolves forwarding hazards for both source registers and selects ALU operand A (register or shift amount) and operand B (register or one of three immediate extensions). It registers the results into the EX stage with valid, stall and flush control. It sits between the register file / decode outputs and the ALU.

## Interface
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width.
- IMM_W, 16, immediate field width; must satisfy IMM_W < DATA_W and 2*IMM_W ≤ DATA_W.
- SHAMT_W, 5, shift-amount width.

- clk  in  1  pipeline clock; all state on rising edge.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- in_valid  in  1  decode slot holds a real instruction.
- stall  in  1  hold the EX-stage register contents.
- flush  in  1  kill the EX-stage slot; overrides stall.
- rs_addr, rt_addr  in  REG_AW each  source register numbers.
- rs_data, rt_data  in  DATA_W each  register-file read data.
- imm  in  IMM_W  instruction immediate.
- shamt  in  SHAMT_W  shift amount.
- alu_src_a  in  1  operand A select: 0 = forwarded rs, 1 = zero-extended shamt.
- alu_src_b  in  2  operand B select: 0 = forwarded rt, 1 = sign-extended imm, 2 = zero-extended imm, 3 = imm << IMM_W (LUI).
- exmem_we, exmem_rd, exmem_res  in  1 / REG_AW / DATA_W  EX/MEM writeback candidate.
- memwb_we, memwb_rd, memwb_res  in  1 / REG_AW / DATA_W  MEM/WB writeback candidate.
- out_valid  out  1  EX-stage slot valid.
- alu_a, alu_b  out  DATA_W each  registered ALU operands.
- store_data  out  DATA_W  registered forwarded rt value, used by SW.
- fwd_a, fwd_b  out  2 each  registered forwarding source per operand (0 = none, 1 = EX/MEM, 2 = MEM/WB), for debug and verification.

## Operation
- Forwarding is evaluated independently for rs and rt:
  - EX/MEM is used if exmem_we, exmem_rd == addr and addr != 0.
  - Otherwise MEM/WB is used under the same rule.
  - Otherwise the register-file data is used.
  - EX/MEM has priority when both match.
- Register 0 is never forwarded. fwd_* = 0 and the raw read data passes through (it is 0 by register-file contract).
- Operand A: alu_src_a = 1 gives {(DATA_W-SHAMT_W) zeros, shamt}; otherwise forwarded rs.
- Operand B:
  - Sign extension replicates imm[IMM_W-1].
  - Zero extension pads zeros.
  - LUI places imm in bits [2*IMM_W-1:IMM_W], with zeros below and zeros above.
- store_data is always forwarded rt, independent of alu_src_b.
- fwd_b reports the rt forwarding source even when alu_src_b != 0.
- The slot register update, in priority order:
  - flush: out_valid <= 0; data registers hold their values.
  - else stall: all registers hold.
  - else: load all registers; out_valid <= in_valid.
- Data registers load regardless of in_valid when not stalled.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on the outputs after edge N.
- Forwarding compare and select are combinational from the inputs in the same cycle as sampling. The team's hazard unit guarantees exmem_* and memwb_* are aligned to the instruction currently in decode.
- Reset: out_valid, alu_a, alu_b, store_data and fwd_* are all 0, asynchronously on rst_n falling. Release is synchronous to clk by the top-level reset synchroniser.
- Reset while stalled or mid-stream discards the slot; the first post-reset edge with stall = 0 loads normally.
- flush and stall together: out_valid <= 0 and data held.
- A stall lasting any number of cycles keeps all outputs bit-stable.

## Structure
- Shared package mips_pkg holds:
  - ALUSRC_B_REG, ALUSRC_B_SEXT, ALUSRC_B_ZEXT, ALUSRC_B_LUI.
  - ALUSRC_A_REG, ALUSRC_A_SHAMT.
  - FWD_NONE, FWD_EXMEM, FWD_MEMWB.
- One sub-module, fwd_sel: a combinational per-operand forwarding comparator and mux that outputs the selected data and the 2-bit source code. It is instantiated twice, for rs and rt.
- The operand muxes and the pipeline register stay in the top module.

## Test plan
- Reset: assert rst_n = 0 mid-operation -> all outputs 0 immediately. Release, then drive in_valid = 1, rs_data = 0x11, alu_src_a = 0 -> after one edge alu_a = 0x11, out_valid = 1.
- Immediate modes, with imm = 0x8001 and DATA_W = 32:
  - alu_src_b = 1 -> alu_b = 0xFFFF8001.
  - alu_src_b = 2 -> alu_b = 0x00008001.
  - alu_src_b = 3 -> alu_b = 0x80010000.
  - shamt = 31 with alu_src_a = 1 -> alu_a = 0x0000001F.
- Forward priority: rs_addr = 4, exmem (we = 1, rd = 4, res = 0xAAAA), memwb (we = 1, rd = 4, res = 0xBBBB) -> alu_a = 0xAAAA, fwd_a = 1. Deassert exmem_we -> alu_a = 0xBBBB, fwd_a = 2.
- Register zero: rt_addr = 0, exmem_rd = 0, exmem_we = 1, exmem_res = 0x1234, alu_src_b = 0 -> alu_b = 0, store_data = 0, fwd_b = 0.
- Stall/flush:
  - Load alu_b = 0x5, then hold stall = 1 for 3 cycles while inputs change -> outputs unchanged.
  - Assert stall = 1 and flush = 1 together -> out_valid = 0, alu_b still 0x5.
  - Release both -> new values load.
- Store forward: alu_src_b = 1, rt_addr = 7, memwb (we = 1, rd = 7, res = 0xCAFE) -> store_data = 0xCAFE, alu_b = sign-extended imm.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings for operand-source selects and forwarding sources.
// Imported by the ID/EX operand stage and its forwarding comparator.
package mips_pkg;

    localparam logic       ALUSRC_A_REG   = 1'b0;
    localparam logic       ALUSRC_A_SHAMT = 1'b1;

    localparam logic [1:0] ALUSRC_B_REG   = 2'd0;
    localparam logic [1:0] ALUSRC_B_SEXT  = 2'd1;
    localparam logic [1:0] ALUSRC_B_ZEXT  = 2'd2;
    localparam logic [1:0] ALUSRC_B_LUI   = 2'd3;

    localparam logic [1:0] FWD_NONE       = 2'd0;
    localparam logic [1:0] FWD_EXMEM      = 2'd1;
    localparam logic [1:0] FWD_MEMWB      = 2'd2;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding comparator and data mux; EX/MEM beats MEM/WB, register 0 never forwards.
// Purely combinational, instantiated once per source register.
module fwd_sel
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              exmem_we,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_res,
    input  logic              memwb_we,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_res,
    output logic [DATA_W-1:0] data,
    output logic [1:0]        src
);

    logic addr_nonzero;
    logic hit_exmem;
    logic hit_memwb;

    assign addr_nonzero = (addr != '0);
    assign hit_exmem    = addr_nonzero && exmem_we && (exmem_rd == addr);
    assign hit_memwb    = addr_nonzero && memwb_we && (memwb_rd == addr);

    always_comb begin
        data = rf_data;
        src  = FWD_NONE;
        if (hit_exmem) begin
            data = exmem_res;
            src  = FWD_EXMEM;
        end else if (hit_memwb) begin
            data = memwb_res;
            src  = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: forwards rs/rt, selects ALU operands A and B, and registers
// them with store data and forwarding sources into the EX slot (flush beats stall).
module alu_operand_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               stall,
    input  logic               flush,
    input  logic [REG_AW-1:0]  rs_addr,
    input  logic [REG_AW-1:0]  rt_addr,
    input  logic [DATA_W-1:0]  rs_data,
    input  logic [DATA_W-1:0]  rt_data,
    input  logic [IMM_W-1:0]   imm,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               alu_src_a,
    input  logic [1:0]         alu_src_b,
    input  logic               exmem_we,
    input  logic [REG_AW-1:0]  exmem_rd,
    input  logic [DATA_W-1:0]  exmem_res,
    input  logic               memwb_we,
    input  logic [REG_AW-1:0]  memwb_rd,
    input  logic [DATA_W-1:0]  memwb_res,
    output logic               out_valid,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [DATA_W-1:0]  store_data,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b
);

    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic [1:0]        rs_src;
    logic [1:0]        rt_src;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_lui;

    fwd_sel #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rs (
        .addr      (rs_addr),
        .rf_data   (rs_data),
        .exmem_we  (exmem_we),
        .exmem_rd  (exmem_rd),
        .exmem_res (exmem_res),
        .memwb_we  (memwb_we),
        .memwb_rd  (memwb_rd),
        .memwb_res (memwb_res),
        .data      (rs_fwd),
        .src       (rs_src)
    );

    fwd_sel #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rt (
        .addr      (rt_addr),
        .rf_data   (rt_data),
        .exmem_we  (exmem_we),
        .exmem_rd  (exmem_rd),
        .exmem_res (exmem_res),
        .memwb_we  (memwb_we),
        .memwb_rd  (memwb_rd),
        .memwb_res (memwb_res),
        .data      (rt_fwd),
        .src       (rt_src)
    );

    // LUI is a widen-then-shift so it stays legal when 2*IMM_W == DATA_W.
    assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_zext = DATA_W'(imm);
    assign imm_lui  = imm_zext << IMM_W;

    always_comb begin
        op_a = rs_fwd;
        if (alu_src_a == ALUSRC_A_SHAMT) begin
            op_a = DATA_W'(shamt);
        end
    end

    always_comb begin
        op_b = rt_fwd;
        case (alu_src_b)
            ALUSRC_B_REG:  op_b = rt_fwd;
            ALUSRC_B_SEXT: op_b = imm_sext;
            ALUSRC_B_ZEXT: op_b = imm_zext;
            ALUSRC_B_LUI:  op_b = imm_lui;
            default:       op_b = rt_fwd;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            store_data <= '0;
            fwd_a      <= FWD_NONE;
            fwd_b      <= FWD_NONE;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid  <= in_valid;
            alu_a      <= op_a;
            alu_b      <= op_b;
            store_data <= rt_fwd;
            fwd_a      <= rs_src;
            fwd_b      <= rt_src;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model of the operand stage.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic [15:0] imm = '0;
    logic [4:0]  shamt = '0;
    logic        alu_src_a = 1'b0;
    logic [1:0]  alu_src_b = 2'd0;
    logic        exmem_we = 1'b0;
    logic [4:0]  exmem_rd = '0;
    logic [31:0] exmem_res = '0;
    logic        memwb_we = 1'b0;
    logic [4:0]  memwb_rd = '0;
    logic [31:0] memwb_res = '0;
    logic        out_valid;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] store_data;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    alu_operand_stage #(
        .DATA_W  (32),
        .REG_AW  (5),
        .IMM_W   (16),
        .SHAMT_W (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .stall      (stall),
        .flush      (flush),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .imm        (imm),
        .shamt      (shamt),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .exmem_we   (exmem_we),
        .exmem_rd   (exmem_rd),
        .exmem_res  (exmem_res),
        .memwb_we   (memwb_we),
        .memwb_rd   (memwb_rd),
        .memwb_res  (memwb_res),
        .out_valid  (out_valid),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .store_data (store_data),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: {source code, value} for a register operand under the forwarding rules.
    function automatic logic [33:0] m_fwd(input logic [4:0] a, input logic [31:0] rf);
        if (a != 0 && exmem_we && exmem_rd == a) return {2'd1, exmem_res};
        if (a != 0 && memwb_we && memwb_rd == a) return {2'd2, memwb_res};
        return {2'd0, rf};
    endfunction

    function automatic logic [31:0] m_opb(input logic [1:0] sel, input logic [31:0] rt);
        int s;
        s = $signed(imm);
        case (sel)
            2'd1:    return 32'(s);
            2'd2:    return 32'(imm);
            2'd3:    return 32'(imm) * 32'h10000;
            default: return rt;
        endcase
    endfunction

    logic        m_valid = 1'b0;
    logic [31:0] m_a = '0, m_b = '0, m_st = '0;
    logic [1:0]  m_fa = '0, m_fb = '0;

    always @(posedge clk or negedge rst_n) begin
        logic [33:0] fs, ft;
        if (!rst_n) begin
            m_valid <= 1'b0; m_a <= '0; m_b <= '0; m_st <= '0; m_fa <= '0; m_fb <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (!stall) begin
            fs = m_fwd(rs_addr, rs_data);
            ft = m_fwd(rt_addr, rt_data);
            m_valid <= in_valid;
            m_a     <= alu_src_a ? 32'(shamt) : fs[31:0];
            m_b     <= m_opb(alu_src_b, ft[31:0]);
            m_st    <= ft[31:0];
            m_fa    <= fs[33:32];
            m_fb    <= ft[33:32];
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model out_valid", 32'(out_valid), 32'(m_valid));
            chk("model alu_a", alu_a, m_a);
            chk("model alu_b", alu_b, m_b);
            chk("model store_data", store_data, m_st);
            chk("model fwd_a", 32'(fwd_a), 32'(m_fa));
            chk("model fwd_b", 32'(fwd_b), 32'(m_fb));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_fwd();
        exmem_we = 1'b0; memwb_we = 1'b0; exmem_rd = '0; memwb_rd = '0;
    endtask

    task automatic randomize_inputs();
        in_valid  = 1'($urandom);
        stall     = ($urandom_range(0, 7) == 0);
        flush     = ($urandom_range(0, 11) == 0);
        rs_addr   = 5'($urandom_range(0, 7));
        rt_addr   = 5'($urandom_range(0, 7));
        rs_data   = (rs_addr == 0) ? 32'h0 : $urandom;
        rt_data   = (rt_addr == 0) ? 32'h0 : $urandom;
        imm       = 16'($urandom);
        shamt     = 5'($urandom);
        alu_src_a = 1'($urandom);
        alu_src_b = 2'($urandom);
        exmem_we  = 1'($urandom);
        exmem_rd  = 5'($urandom_range(0, 7));
        exmem_res = $urandom;
        memwb_we  = 1'($urandom);
        memwb_rd  = 5'($urandom_range(0, 7));
        memwb_res = $urandom;
    endtask

    initial begin
        #12;
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset alu_a", alu_a, 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Run some traffic, then reset mid-stream between edges.
        for (int i = 0; i < 20; i++) begin
            randomize_inputs();
            step();
        end
        in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'h0);
        chk("async reset alu_a", alu_a, 32'h0);
        chk("async reset alu_b", alu_b, 32'h0);
        chk("async reset store_data", store_data, 32'h0);
        chk("async reset fwd", {28'h0, fwd_a, fwd_b}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        clear_fwd();
        stall = 1'b0; flush = 1'b0; in_valid = 1'b1;
        rs_addr = 5'd3; rs_data = 32'h11; alu_src_a = 1'b0;
        step();
        chk("post reset alu_a", alu_a, 32'h11);
        chk("post reset out_valid", 32'(out_valid), 32'h1);

        imm = 16'h8001;
        alu_src_b = 2'd1; step(); chk("sext imm", alu_b, 32'hFFFF8001);
        alu_src_b = 2'd2; step(); chk("zext imm", alu_b, 32'h00008001);
        alu_src_b = 2'd3; step(); chk("lui imm", alu_b, 32'h80010000);
        shamt = 5'd31; alu_src_a = 1'b1; step(); chk("shamt", alu_a, 32'h0000001F);

        alu_src_a = 1'b0; rs_addr = 5'd4;
        exmem_we = 1'b1; exmem_rd = 5'd4; exmem_res = 32'hAAAA;
        memwb_we = 1'b1; memwb_rd = 5'd4; memwb_res = 32'hBBBB;
        step();
        chk("prio exmem alu_a", alu_a, 32'hAAAA);
        chk("prio exmem fwd_a", 32'(fwd_a), 32'd1);
        exmem_we = 1'b0; step();
        chk("memwb alu_a", alu_a, 32'hBBBB);
        chk("memwb fwd_a", 32'(fwd_a), 32'd2);

        clear_fwd();
        rt_addr = 5'd0; rt_data = 32'h0; alu_src_b = 2'd0;
        exmem_we = 1'b1; exmem_rd = 5'd0; exmem_res = 32'h1234;
        step();
        chk("r0 alu_b", alu_b, 32'h0);
        chk("r0 store_data", store_data, 32'h0);
        chk("r0 fwd_b", 32'(fwd_b), 32'd0);

        clear_fwd();
        rt_addr = 5'd9; rt_data = 32'h5; in_valid = 1'b1; step();
        chk("stall preload alu_b", alu_b, 32'h5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rt_data = 32'h77 + 32'(i); in_valid = 1'b0; rs_data = $urandom;
            step();
            chk("stall hold alu_b", alu_b, 32'h5);
            chk("stall hold out_valid", 32'(out_valid), 32'h1);
        end
        flush = 1'b1; step();
        chk("flush+stall out_valid", 32'(out_valid), 32'h0);
        chk("flush+stall alu_b", alu_b, 32'h5);
        stall = 1'b0; flush = 1'b0; in_valid = 1'b1; rt_data = 32'h77; step();
        chk("release alu_b", alu_b, 32'h77);
        chk("release out_valid", 32'(out_valid), 32'h1);

        alu_src_b = 2'd1; imm = 16'h8001; rt_addr = 5'd7;
        memwb_we = 1'b1; memwb_rd = 5'd7; memwb_res = 32'hCAFE;
        step();
        chk("store fwd store_data", store_data, 32'hCAFE);
        chk("store fwd alu_b", alu_b, 32'hFFFF8001);
        chk("store fwd fwd_b", 32'(fwd_b), 32'd2);

        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            if (i == 1500) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            step();
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
